// File: rtl/scan_sequencer.sv
// Row/column scan controller: walks a ROWS x COLS region one beat per
// valid/ready handshake and pulses done once the final beat is accepted.
module scan_sequencer #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int RW   = 2,
    parameter int CW   = 2,
    parameter int AW   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          ready,
    output logic          valid,
    output logic [RW-1:0] row_idx,
    output logic [CW-1:0] col_idx,
    output logic [AW-1:0] addr,
    output logic          first,
    output logic          last,
    output logic          row_end,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    state_t        state_r, state_s;
    logic [RW-1:0] row_r, row_s;
    logic [CW-1:0] col_r, col_s;
    logic [AW-1:0] addr_r, addr_s;
    logic          at_row_end_s;
    logic          at_last_s;

    assign at_row_end_s = (col_r == COL_MAX);
    assign at_last_s    = at_row_end_s && (row_r == ROW_MAX);

    // State and index registers; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            row_r   <= '0;
            col_r   <= '0;
            addr_r  <= '0;
        end else begin
            state_r <= state_s;
            row_r   <= row_s;
            col_r   <= col_s;
            addr_r  <= addr_s;
        end
    end

    // Next-state and index advance; indices hold unless a handshake occurs.
    always_comb begin
        state_s = state_r;
        row_s   = row_r;
        col_s   = col_r;
        addr_s  = addr_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                    row_s   = '0;
                    col_s   = '0;
                    addr_s  = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // abort outranks a handshake, even on the final beat
                if (abort) begin
                    state_s = IDLE;
                    row_s   = '0;
                    col_s   = '0;
                    addr_s  = '0;
                end else if (ready) begin
                    if (at_last_s) begin
                        state_s = DONE;
                        row_s   = '0;
                        col_s   = '0;
                        addr_s  = '0;
                    end else if (at_row_end_s) begin
                        row_s  = row_r + RW'(1);
                        col_s  = '0;
                        addr_s = addr_r + AW'(1);
                    end else begin
                        col_s  = col_r + CW'(1);
                        addr_s = addr_r + AW'(1);
                    end
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                row_s   = '0;
                col_s   = '0;
                addr_s  = '0;
            end
        endcase
    end

    assign valid   = (state_r == RUN);
    assign busy    = (state_r == RUN);
    assign done    = (state_r == DONE);
    assign row_idx = row_r;
    assign col_idx = col_r;
    assign addr    = addr_r;
    assign first   = valid && (row_r == '0) && (col_r == '0);
    assign last    = valid && at_last_s;
    assign row_end = valid && at_row_end_s;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: a 3x4 instance for the main scenarios
// and a 1x1 instance for the degenerate single-beat case.
module tb_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst, start, abort, ready;
    logic       valid, first, last, row_end, busy, done;
    logic [1:0] row_idx, col_idx;
    logic [3:0] addr;

    logic       start1, ready1;
    logic       valid1, first1, last1, row_end1, busy1, done1;
    logic       row_idx1, col_idx1, addr1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scan_sequencer #(.ROWS(3), .COLS(4), .RW(2), .CW(2), .AW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ready(ready),
        .valid(valid), .row_idx(row_idx), .col_idx(col_idx), .addr(addr),
        .first(first), .last(last), .row_end(row_end), .busy(busy), .done(done)
    );

    scan_sequencer #(.ROWS(1), .COLS(1), .RW(1), .CW(1), .AW(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .ready(ready1),
        .valid(valid1), .row_idx(row_idx1), .col_idx(col_idx1), .addr(addr1),
        .first(first1), .last(last1), .row_end(row_end1), .busy(busy1), .done(done1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, ".valid"}, 32'(valid), 32'd0);
        check_eq({tag, ".busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".done"}, 32'(done), 32'd0);
        check_eq({tag, ".addr"}, 32'(addr), 32'd0);
        check_eq({tag, ".row"}, 32'(row_idx), 32'd0);
        check_eq({tag, ".col"}, 32'(col_idx), 32'd0);
        check_eq({tag, ".flags"}, 32'({first, last, row_end}), 32'd0);
    endtask

    task automatic check_beat(input int k);
        string t;
        t = $sformatf("beat%0d", k);
        check_eq({t, ".valid"}, 32'(valid), 32'd1);
        check_eq({t, ".busy"}, 32'(busy), 32'd1);
        check_eq({t, ".done"}, 32'(done), 32'd0);
        check_eq({t, ".row"}, 32'(row_idx), 32'(k / 4));
        check_eq({t, ".col"}, 32'(col_idx), 32'(k % 4));
        check_eq({t, ".addr"}, 32'(addr), 32'(k));
        check_eq({t, ".first"}, 32'(first), 32'(k == 0));
        check_eq({t, ".last"}, 32'(last), 32'(k == 11));
        check_eq({t, ".row_end"}, 32'(row_end), 32'(k % 4 == 3));
    endtask

    task automatic start_scan();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full scan with ready high, then the done cycle and return to idle.
    task automatic full_scan(input string tag);
        for (int k = 0; k < 12; k++) begin
            check_beat(k);
            step();
        end
        check_eq({tag, ".done"}, 32'(done), 32'd1);
        check_eq({tag, ".done_valid"}, 32'(valid), 32'd0);
        check_eq({tag, ".done_busy"}, 32'(busy), 32'd0);
        check_eq({tag, ".done_addr"}, 32'(addr), 32'd0);
        step();
        check_idle({tag, ".after"});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1;
        start1 = 1'b0; ready1 = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        check_idle("reset");

        // Scan with ready held high
        start_scan();
        full_scan("scan1");

        // Ready toggling 1,0,1,0...
        start_scan();
        k = 0;
        cyc = 0;
        while (valid === 1'b1 && cyc < 100) begin
            ready = (cyc % 2 == 0);
            check_beat(k);
            if (ready) k++;
            step();
            cyc++;
        end
        ready = 1'b1;
        check_eq("toggle.handshakes", 32'(k), 32'd12);
        check_eq("toggle.run_cycles", 32'(cyc), 32'd23);
        check_eq("toggle.done", 32'(done), 32'd1);
        step();
        check_idle("toggle.after");

        // Abort at addr 5
        start_scan();
        for (int i = 0; i < 5; i++) begin
            check_beat(i);
            step();
        end
        check_beat(5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("abort");
        step();
        check_idle("abort.idle");
        start_scan();
        full_scan("abort.restart");

        // start during RUN and during DONE is ignored
        start_scan();
        for (int i = 0; i < 12; i++) begin
            start = (i == 4);
            check_beat(i);
            step();
        end
        check_eq("ign.done", 32'(done), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        check_idle("ign.after_done");
        step();
        check_idle("ign.still_idle");

        // rst at addr 7
        start_scan();
        for (int i = 0; i < 7; i++) begin
            check_beat(i);
            step();
        end
        check_beat(7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("rst_mid");
        step();
        check_idle("rst_mid.idle");
        start_scan();
        full_scan("rst.restart");

        // 1x1 degenerate scan
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check_eq("one.valid", 32'(valid1), 32'd1);
        check_eq("one.addr", 32'(addr1), 32'd0);
        check_eq("one.flags", 32'({first1, last1, row_end1}), 32'd7);
        check_eq("one.done_early", 32'(done1), 32'd0);
        step();
        check_eq("one.done", 32'(done1), 32'd1);
        check_eq("one.done_valid", 32'(valid1), 32'd0);
        check_eq("one.done_busy", 32'(busy1), 32'd0);
        step();
        check_eq("one.after_done", 32'(done1), 32'd0);
        check_eq("one.after_valid", 32'(valid1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Sequences the row/column walk over a ROWS x COLS region for the datapath's index and address generation; replaces ad-hoc chains of mod-N counters with a single controller.
- Emits one (row, col, addr) beat per valid/ready handshake, flags region boundaries, and signals completion with a one-cycle done pulse.
- Sits between the top-level control FSM (start/abort) and the memory/PE datapath (ready backpressure).

Parameters:
- ROWS, 4, number of rows in the scan (>=1)
- COLS, 4, number of columns per row (>=1)
- RW, 2, width of row_idx; must hold ROWS-1
- CW, 2, width of col_idx; must hold COLS-1
- AW, 4, width of addr; must hold ROWS*COLS-1

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset
- start  input  1  begin a scan; sampled only in IDLE
- abort  input  1  terminate an active scan
- ready  input  1  downstream accepts current beat
- valid  output  1  current beat (row_idx, col_idx, addr) is presented
- row_idx  output  RW  current row, 0..ROWS-1
- col_idx  output  CW  current column, 0..COLS-1
- addr  output  AW  linear index row_idx*COLS+col_idx
- first  output  1  valid beat is (0,0)
- last  output  1  valid beat is (ROWS-1,COLS-1)
- row_end  output  1  valid beat has col_idx==COLS-1
- busy  output  1  state is RUN
- done  output  1  one-cycle completion pulse

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. rst has priority over every other input.
- Reset state: IDLE. row_idx=0, col_idx=0, addr=0; valid, first, last, row_end, busy and done are all 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge -> RUN at that edge; row, col and addr are cleared to 0.
  - abort is ignored in IDLE.
- RUN:
  - valid=1 and busy=1.
  - A handshake is valid&&ready at a rising edge. Indices advance only on a handshake and otherwise hold (ready=0 stalls with no limit).
  - On a handshake: col_idx increments. If col_idx==COLS-1, col_idx wraps to 0 and row_idx increments. addr increments by 1. addr is kept as an incremental counter, not a multiplier.
  - A handshake on the last beat (ROWS-1, COLS-1) -> DONE. Indices wrap to 0, so row_idx, col_idx and addr are all 0 in DONE.
  - abort=1 -> IDLE at that edge; indices cleared; no done pulse.
  - If abort and ready are both 1 on the last beat, abort wins: no done pulse.
- DONE:
  - done=1 for exactly one cycle; valid=0, busy=0.
  - Unconditional transition to IDLE.
  - start in DONE is ignored; the next scan needs start in IDLE.
- start while in RUN or DONE has no effect.
- Flags are combinational from state and indices, and gated by valid:
  - first = valid && row==0 && col==0
  - last = valid && row==ROWS-1 && col==COLS-1
  - row_end = valid && col==COLS-1
- Latency:
  - start edge -> first valid beat in the next cycle.
  - A scan with ready held high takes ROWS*COLS RUN cycles plus 1 DONE cycle.
  - A back-to-back restart needs an IDLE cycle, so the minimum start-to-start period is ROWS*COLS+2 cycles.
- Degenerate sizes:
  - ROWS=1, COLS=1: the single beat has first=last=row_end=1.
  - COLS=1: row_end=1 on every beat.
- rst asserted mid-RUN or in DONE -> IDLE with all outputs at reset values at the next edge; no done pulse.
- Index and address counters never exceed their modulus; no wrap to out-of-range values for any legal parameter set.

Test Plan:
- ROWS=3, COLS=4, ready=1, pulse start -> 12 consecutive valid beats, addr 0..11, (row,col) = (0,0)..(2,3); row_end on addr 3, 7, 11; first on addr 0; last on addr 11; done=1 exactly one cycle later, then busy=0.
- Same config, ready toggling 1,0,1,0... -> each beat held while ready=0; 12 handshakes total in 23 RUN cycles; addr sequence is unchanged and has no skips.
- abort at addr=5 with ready=1 -> next cycle IDLE, valid=0, addr=0, done never asserts; a later start restarts at addr 0.
- start pulsed at addr 4 in RUN and again in the DONE cycle -> no effect; exactly one done pulse; the next scan begins only after start in IDLE.
- rst high for one cycle at addr 7 -> next cycle all outputs at reset values, no done; a start afterwards runs a complete 12-beat scan.
- ROWS=1, COLS=1, start, ready=1 -> one beat with addr=0, first=last=row_end=1; done in the following cycle.
